// File: rtl/vga_fb_arbiter.sv
// Frame-RAM arbiter: beam-ahead pixel fetch with priority, queued writes drained in idle slots.
// Optional frame clear during vertical blank is built when VGA_FB_CLEAR_EN is defined.
module vga_fb_arbiter #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h,
    input  logic [9:0]  v,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [11:0] rgb_pix,
    output logic        err_oob,
    input  logic        clear_req,
    output logic        clear_busy
);

    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned PW      = $clog2(FIFO_DEPTH);

    // Beam position two clocks ahead, wrapping across line and frame ends
    logic [10:0] h_sum;
    logic [9:0]  hn;
    logic [9:0]  line;
    logic        fetch;
    logic [14:0] fetch_addr;

    always_comb begin
        h_sum = {1'b0, h} + 11'd2;
        hn    = h_sum[9:0];
        line  = v;
        if (h_sum >= 11'(H_TOTAL)) begin
            hn   = 10'(h_sum - 11'(H_TOTAL));
            line = (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
        end
    end

    assign fetch      = (hn[1:0] == 2'b00) && (hn < 10'(H_DISPLAY)) && (line < 10'(V_DISPLAY));
    assign fetch_addr = 15'((32'(line >> 2) * FB_W) + 32'(hn >> 2));

    // Write queue
    logic [14:0] fifo_addr_q [FIFO_DEPTH];
    logic [11:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic full, empty, push, pop, head_ok;
    logic clear_active, clear_wr;
    logic [14:0] clr_addr;

    assign full     = (count_q == (PW + 1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = !fetch && !empty && !clear_active;
    assign head_ok  = (fifo_addr_q[rptr_q] < 15'(FB_SIZE));

`ifdef VGA_FB_CLEAR_EN
    typedef enum logic [1:0] {ClrIdle, ClrWaitVb, ClrRun} clr_state_e;

    clr_state_e  clr_state_q;
    logic [14:0] clr_addr_q;
    logic        clr_busy_q;
    logic        clr_start;

    // The clear begins in the very cycle the blanking line is reached
    assign clr_start    = (clr_state_q == ClrWaitVb) && (v == 10'(V_DISPLAY)) && (h == 10'd0);
    assign clear_active = (clr_state_q == ClrRun) || clr_start;
    assign clear_wr     = clear_active && !fetch;
    assign clr_addr     = clr_addr_q;
    assign clear_busy   = clr_busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_state_q <= ClrIdle;
            clr_addr_q  <= '0;
            clr_busy_q  <= 1'b0;
        end else begin
            case (clr_state_q)
                ClrIdle: begin
                    if (clear_req) begin
                        clr_state_q <= ClrWaitVb;
                        clr_busy_q  <= 1'b1;
                        clr_addr_q  <= '0;
                    end
                end
                ClrWaitVb: begin
                    if (clr_start) begin
                        clr_state_q <= ClrRun;
                        if (clear_wr) clr_addr_q <= clr_addr_q + 15'd1;
                    end
                end
                ClrRun: begin
                    if (clear_wr) begin
                        if (clr_addr_q == 15'(FB_SIZE - 1)) begin
                            clr_state_q <= ClrIdle;
                            clr_busy_q  <= 1'b0;
                            clr_addr_q  <= '0;
                        end else begin
                            clr_addr_q <= clr_addr_q + 15'd1;
                        end
                    end
                end
                default: begin
                    clr_state_q <= ClrIdle;
                    clr_busy_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign clear_active     = 1'b0;
    assign clear_wr         = 1'b0;
    assign clr_addr         = '0;
    assign clear_busy       = 1'b0;
`endif

    // RAM port: fetch first, then clear, then queued writes; gated off during reset
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (fetch) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (clear_wr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = CLEAR_COLOR;
        end else if (pop && head_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_addr_q[rptr_q];
            mem_wdata = fifo_data_q[rptr_q];
        end
        if (!rst_n) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr;
            fifo_data_q[wptr_q] <= wr_data;
        end
    end

    logic fetch_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rgb_pix <= '0;
            err_oob <= 1'b0;
            fetch_q <= 1'b0;
        end else begin
            fetch_q <= fetch;
            if (fetch_q) rgb_pix <= mem_rdata;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
                if (wr_addr >= 15'(FB_SIZE)) err_oob <= 1'b1;
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
